// File: rtl/prot_sequencer.sv
// Input-protection relay sequencer: arms after a run of good input, trips on a bad input,
// holds off and re-arms, and locks out after repeated faults. Macro PROT_FAULT_BLINK_EN blinks the fault LED in LOCKOUT.
module prot_sequencer #(
    parameter int unsigned ARM_CYCLES     = 16,
    parameter int unsigned HOLDOFF_CYCLES = 108,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned BLINK_DIV_LOG2 = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vin_too_high,
    input  logic       vin_not_negative,
    input  logic       clear_fault,
    output logic       prot_relay_en,
    output logic       ok_led_en,
    output logic       fault_led_en,
    output logic       vhi_led_en,
    output logic       vlo_led_en,
    output logic [2:0] fault_count
);

    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        ON      = 2'd1,
        FAULT   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [7:0] ARM_LAST  = 8'(ARM_CYCLES - 1);
    localparam logic [7:0] ARM_TERM  = 8'(ARM_CYCLES);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);
    localparam logic [2:0] MAX_RET   = 3'(MAX_RETRIES);

    state_t     state_q, state_d;
    logic [7:0] arm_cnt_q, arm_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] fault_cnt_q, fault_cnt_d;
    logic       vhi_q, vhi_d, vlo_q, vlo_d;
    logic       th_meta_q, th_sync_q, nn_meta_q, nn_sync_q;
    logic       clr_meta_q, clr_sync_q, clr_prev_q;
    logic       relay_q, ok_led_q, fault_led_q;
    logic       input_ok_s, clr_rise_s, blink_on_s, fault_led_d;

    assign input_ok_s = nn_sync_q & ~th_sync_q;
    assign clr_rise_s = clr_sync_q & ~clr_prev_q;

`ifdef PROT_FAULT_BLINK_EN
    logic [BLINK_DIV_LOG2:0] blink_cnt_q;

    // Free-running blink divider; its MSB gives a 2^(BLINK_DIV_LOG2+1)-cycle square wave.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + {{BLINK_DIV_LOG2{1'b0}}, 1'b1};
        end
    end

    assign blink_on_s = blink_cnt_q[BLINK_DIV_LOG2];
`else
    assign blink_on_s = 1'b1;
`endif

    // Next-state logic for the sequencer, its counters and the fault-cause flags.
    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        fault_cnt_d = fault_cnt_q;
        vhi_d       = vhi_q;
        vlo_d       = vlo_q;
        case (state_q)
            ARMING: begin
                if (!input_ok_s) begin
                    arm_cnt_d = 8'd0;
                end else if (arm_cnt_q >= ARM_LAST) begin
                    state_d   = ON;
                    arm_cnt_d = 8'd0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 8'd1;
                end
            end
            ON: begin
                if (!input_ok_s) begin
                    state_d     = FAULT;
                    arm_cnt_d   = 8'd0;
                    hold_cnt_d  = 8'd0;
                    fault_cnt_d = (fault_cnt_q == 3'd7) ? 3'd7 : fault_cnt_q + 3'd1;
                    vhi_d       = vhi_q | th_sync_q;
                    vlo_d       = vlo_q | ~nn_sync_q;
                end else if (arm_cnt_q < ARM_TERM) begin
                    arm_cnt_d = arm_cnt_q + 8'd1;
                    // A full arm-length of clean running forgives earlier faults.
                    if (arm_cnt_q == ARM_LAST) begin
                        fault_cnt_d = 3'd0;
                        vhi_d       = 1'b0;
                        vlo_d       = 1'b0;
                    end else begin
                        fault_cnt_d = fault_cnt_q;
                    end
                end else begin
                    arm_cnt_d = arm_cnt_q;
                end
            end
            FAULT: begin
                if (hold_cnt_q >= HOLD_LAST) begin
                    hold_cnt_d = 8'd0;
                    state_d    = (fault_cnt_q >= MAX_RET) ? LOCKOUT : ARMING;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            LOCKOUT: begin
                if (clr_rise_s) begin
                    state_d     = ARMING;
                    arm_cnt_d   = 8'd0;
                    fault_cnt_d = 3'd0;
                    vhi_d       = 1'b0;
                    vlo_d       = 1'b0;
                end else begin
                    state_d = LOCKOUT;
                end
            end
            default: begin
                state_d = ARMING;
            end
        endcase
    end

    assign fault_led_d = (state_d == FAULT) || ((state_d == LOCKOUT) && blink_on_s);

    // Synchronizers, state registers and outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            th_meta_q   <= 1'b0;
            th_sync_q   <= 1'b0;
            nn_meta_q   <= 1'b0;
            nn_sync_q   <= 1'b0;
            clr_meta_q  <= 1'b0;
            clr_sync_q  <= 1'b0;
            clr_prev_q  <= 1'b0;
            state_q     <= ARMING;
            arm_cnt_q   <= 8'd0;
            hold_cnt_q  <= 8'd0;
            fault_cnt_q <= 3'd0;
            vhi_q       <= 1'b0;
            vlo_q       <= 1'b0;
            relay_q     <= 1'b0;
            ok_led_q    <= 1'b0;
            fault_led_q <= 1'b0;
        end else begin
            th_meta_q   <= vin_too_high;
            th_sync_q   <= th_meta_q;
            nn_meta_q   <= vin_not_negative;
            nn_sync_q   <= nn_meta_q;
            clr_meta_q  <= clear_fault;
            clr_sync_q  <= clr_meta_q;
            clr_prev_q  <= clr_sync_q;
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            vhi_q       <= vhi_d;
            vlo_q       <= vlo_d;
            relay_q     <= (state_d == ON);
            ok_led_q    <= (state_d == ON);
            fault_led_q <= fault_led_d;
        end
    end

    assign prot_relay_en = relay_q;
    assign ok_led_en     = ok_led_q;
    assign fault_led_en  = fault_led_q;
    assign vhi_led_en    = vhi_q;
    assign vlo_led_en    = vlo_q;
    assign fault_count   = fault_cnt_q;

endmodule

// File: tb/tb_prot_sequencer.sv
// Directed self-checking bench for prot_sequencer with default parameters.
module tb_prot_sequencer;

    logic       clk;
    logic       rst;
    logic       vin_too_high;
    logic       vin_not_negative;
    logic       clear_fault;
    logic       prot_relay_en;
    logic       ok_led_en;
    logic       fault_led_en;
    logic       vhi_led_en;
    logic       vlo_led_en;
    logic [2:0] fault_count;

    int checks = 0;
    int errors = 0;

    prot_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .vin_too_high     (vin_too_high),
        .vin_not_negative (vin_not_negative),
        .clear_fault      (clear_fault),
        .prot_relay_en    (prot_relay_en),
        .ok_led_en        (ok_led_en),
        .fault_led_en     (fault_led_en),
        .vhi_led_en       (vhi_led_en),
        .vlo_led_en       (vlo_led_en),
        .fault_count      (fault_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // From ON: hold the chosen bad condition for one cycle; trip is seen on the 3rd edge.
    task automatic fault_pulse(input logic th_bad, input logic nn_bad, input logic [2:0] exp_fc,
                               input logic exp_vhi, input logic exp_vlo);
        vin_too_high     = th_bad;
        vin_not_negative = ~nn_bad;
        step(1);
        vin_too_high     = 1'b0;
        vin_not_negative = 1'b1;
        step(2);
        check("trip_relay", {7'd0, prot_relay_en}, 8'd0);
        check("trip_fault_led", {7'd0, fault_led_en}, 8'd1);
        check("trip_fc", {5'd0, fault_count}, {5'd0, exp_fc});
        check("trip_vhi", {7'd0, vhi_led_en}, {7'd0, exp_vhi});
        check("trip_vlo", {7'd0, vlo_led_en}, {7'd0, exp_vlo});
    endtask

    initial begin
        int led_hi;
        int relay_hi;
        rst              = 1'b1;
        vin_too_high     = 1'b0;
        vin_not_negative = 1'b1;
        clear_fault      = 1'b0;
        step(3);
        check("rst_relay", {7'd0, prot_relay_en}, 8'd0);
        check("rst_ok", {7'd0, ok_led_en}, 8'd0);
        check("rst_fault_led", {7'd0, fault_led_en}, 8'd0);
        check("rst_flags", {6'd0, vhi_led_en, vlo_led_en}, 8'd0);
        check("rst_fc", {5'd0, fault_count}, 8'd0);
        rst = 1'b0;

        // Arm: 2 sync edges then 16 good ARMING cycles.
        step(17);
        check("arm_relay_early", {7'd0, prot_relay_en}, 8'd0);
        step(1);
        check("arm_relay_on", {7'd0, prot_relay_en}, 8'd1);
        check("arm_ok_led", {7'd0, ok_led_en}, 8'd1);
        check("arm_fc", {5'd0, fault_count}, 8'd0);

        // Single over-voltage glitch, holdoff, re-arm, forgiveness.
        fault_pulse(1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        step(107);
        check("hold_last_led", {7'd0, fault_led_en}, 8'd1);
        check("hold_last_relay", {7'd0, prot_relay_en}, 8'd0);
        step(1);
        check("rearm_led", {7'd0, fault_led_en}, 8'd0);
        check("rearm_relay", {7'd0, prot_relay_en}, 8'd0);
        step(15);
        check("rearm_relay_early", {7'd0, prot_relay_en}, 8'd0);
        step(1);
        check("rearm_relay_on", {7'd0, prot_relay_en}, 8'd1);
        check("rearm_vhi_kept", {7'd0, vhi_led_en}, 8'd1);
        check("rearm_fc_kept", {5'd0, fault_count}, 8'd1);
        step(15);
        check("forgive_vhi_early", {7'd0, vhi_led_en}, 8'd1);
        check("forgive_fc_early", {5'd0, fault_count}, 8'd1);
        step(1);
        check("forgive_vhi", {7'd0, vhi_led_en}, 8'd0);
        check("forgive_fc", {5'd0, fault_count}, 8'd0);

        // Both inputs bad together, then two more quick faults into LOCKOUT.
        fault_pulse(1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
        step(108);
        check("f1_rearm_led", {7'd0, fault_led_en}, 8'd0);
        step(16);
        check("f1_on", {7'd0, prot_relay_en}, 8'd1);
        fault_pulse(1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
        step(124);
        check("f2_on", {7'd0, prot_relay_en}, 8'd1);
        fault_pulse(1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
        step(108);
        check("lock_fc", {5'd0, fault_count}, 8'd3);
        led_hi   = 0;
        relay_hi = 0;
        for (int i = 0; i < 64; i++) begin
            led_hi   += int'(fault_led_en);
            relay_hi += int'(prot_relay_en) + int'(ok_led_en);
            step(1);
        end
`ifdef PROT_FAULT_BLINK_EN
        check("lock_blink_duty", 8'(led_hi), 8'd32);
`else
        check("lock_led_solid", 8'(led_hi), 8'd64);
`endif
        check("lock_relay_off", 8'(relay_hi), 8'd0);
        step(100);
        check("lock_still_off", {7'd0, prot_relay_en}, 8'd0);

        // Clear from LOCKOUT: seen on the 3rd edge after the pulse starts.
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        step(1);
        check("clr_fc_pending", {5'd0, fault_count}, 8'd3);
        step(1);
        check("clr_fc", {5'd0, fault_count}, 8'd0);
        check("clr_flags", {6'd0, vhi_led_en, vlo_led_en}, 8'd0);
        check("clr_led", {7'd0, fault_led_en}, 8'd0);
        step(15);
        check("clr_arm_early", {7'd0, prot_relay_en}, 8'd0);
        step(1);
        check("clr_arm_on", {7'd0, prot_relay_en}, 8'd1);

        // clear_fault while ON does nothing.
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        step(5);
        check("clr_in_on_relay", {7'd0, prot_relay_en}, 8'd1);
        check("clr_in_on_ok", {7'd0, ok_led_en}, 8'd1);

        // Reset mid-holdoff leaves nothing behind.
        fault_pulse(1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        step(50);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_relay", {7'd0, prot_relay_en}, 8'd0);
        check("midrst_fault_led", {7'd0, fault_led_en}, 8'd0);
        check("midrst_flags", {6'd0, vhi_led_en, vlo_led_en}, 8'd0);
        check("midrst_fc", {5'd0, fault_count}, 8'd0);

        // Bad input during ARMING only restarts the arm count.
        step(8);
        vin_too_high = 1'b1;
        step(1);
        vin_too_high = 1'b0;
        step(2);
        check("arm_glitch_led", {7'd0, fault_led_en}, 8'd0);
        check("arm_glitch_fc", {5'd0, fault_count}, 8'd0);
        step(15);
        check("arm_glitch_early", {7'd0, prot_relay_en}, 8'd0);
        step(1);
        check("arm_glitch_on", {7'd0, prot_relay_en}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
